// File: rtl/sdram_cmd_arbiter.sv
// Arbitrates acquisition writes and SPI readback reads onto one SDRAM command port.
// Optional read-starvation guard enabled by defining SDRAM_ARB_FAIRNESS_EN.
module sdram_cmd_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 21,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned RD_TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    input  logic                  cmd_ready,
    output logic                  cmd_enable,
    output logic                  cmd_wr,
    output logic [ADDR_WIDTH-1:0] cmd_address,
    output logic [DATA_WIDTH-1:0] cmd_data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  data_out_ready,
    output logic                  busy
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE_WR = 2'd1;
    localparam logic [1:0] S_ISSUE_RD = 2'd2;
    localparam logic [1:0] S_RD_WAIT  = 2'd3;

    logic [1:0]            state, state_next;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_next, wait_inc;
    logic                  cmd_enable_next, cmd_wr_next;
    logic [ADDR_WIDTH-1:0] cmd_address_next;
    logic [DATA_WIDTH-1:0] cmd_data_in_next, rd_data_next;
    logic                  wr_ack_next, rd_ack_next, rd_valid_next, rd_err_next;
    logic                  busy_next;
    logic                  grant_wr, grant_rd;
    logic                  starved;

`ifdef SDRAM_ARB_FAIRNESS_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt, starve_cnt_next;

    assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Count writes granted over a waiting read; any read grant or read-free idle cycle resets it.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (grant_rd) begin
            starve_cnt_next = '0;
        end else if (grant_wr && rd_req) begin
            if (!starved) starve_cnt_next = starve_cnt + STARVE_W'(1);
        end else if (state == S_IDLE && !rd_req) begin
            starve_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_cnt <= '0;
        else          starve_cnt <= starve_cnt_next;
    end
`else
    assign starved = 1'b0;
`endif

    // Next-state and registered-output logic. The IDLE cycle carrying an ack/valid pulse
    // makes no grant, so a requester still holding req during its ack is not served twice.
    always_comb begin
        state_next       = state;
        cmd_enable_next  = cmd_enable;
        cmd_wr_next      = cmd_wr;
        cmd_address_next = cmd_address;
        cmd_data_in_next = cmd_data_in;
        wr_ack_next      = 1'b0;
        rd_ack_next      = 1'b0;
        rd_valid_next    = 1'b0;
        rd_data_next     = rd_data;
        rd_err_next      = rd_err;
        wait_cnt_next    = wait_cnt;
        wait_inc         = wait_cnt + WAIT_W'(1);
        grant_wr         = 1'b0;
        grant_rd         = 1'b0;

        case (state)
            S_IDLE: begin
                if (!(wr_ack || rd_valid)) begin
                    if (wr_req && !(rd_req && starved)) grant_wr = 1'b1;
                    else if (rd_req)                    grant_rd = 1'b1;
                end
                if (grant_wr) begin
                    state_next       = S_ISSUE_WR;
                    cmd_enable_next  = 1'b1;
                    cmd_wr_next      = 1'b1;
                    cmd_address_next = wr_addr;
                    cmd_data_in_next = wr_data;
                end else if (grant_rd) begin
                    state_next       = S_ISSUE_RD;
                    cmd_enable_next  = 1'b1;
                    cmd_wr_next      = 1'b0;
                    cmd_address_next = rd_addr;
                    cmd_data_in_next = '0;
                end
            end
            S_ISSUE_WR: begin
                if (cmd_ready) begin
                    state_next      = S_IDLE;
                    cmd_enable_next = 1'b0;
                    wr_ack_next     = 1'b1;
                end
            end
            S_ISSUE_RD: begin
                if (cmd_ready) begin
                    state_next      = S_RD_WAIT;
                    cmd_enable_next = 1'b0;
                    rd_ack_next     = 1'b1;
                    wait_cnt_next   = '0;
                end
            end
            S_RD_WAIT: begin
                if (data_out_ready) begin
                    state_next    = S_IDLE;
                    rd_valid_next = 1'b1;
                    rd_data_next  = data_out;
                end else if (wait_inc == WAIT_W'(RD_TIMEOUT)) begin
                    state_next    = S_IDLE;
                    rd_valid_next = 1'b1;
                    rd_data_next  = '0;
                    rd_err_next   = 1'b1;
                    wait_cnt_next = wait_inc;
                end else begin
                    wait_cnt_next = wait_inc;
                end
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cmd_enable  <= 1'b0;
            cmd_wr      <= 1'b0;
            cmd_address <= '0;
            cmd_data_in <= '0;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_err      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            cmd_enable  <= cmd_enable_next;
            cmd_wr      <= cmd_wr_next;
            cmd_address <= cmd_address_next;
            cmd_data_in <= cmd_data_in_next;
            wr_ack      <= wr_ack_next;
            rd_ack      <= rd_ack_next;
            rd_valid    <= rd_valid_next;
            rd_data     <= rd_data_next;
            rd_err      <= rd_err_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 21: word-address width of the SDRAM command port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: command data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8: consecutive write grants allowed while a read is pending.
REQ-004 SHALL have parameter RD_TIMEOUT, default 255: cycles to wait for read data before aborting.
REQ-005 SHALL have ports:
- clk  in  1  sole clock (fpga_clk domain).
- reset_n  in  1  reset, asynchronous, active-low.
- wr_req  in  1  acquisition write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_ack  out  1  one-cycle pulse: write accepted by the SDRAM controller.
- rd_req  in  1  SPI readback request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_ack  out  1  one-cycle pulse: read command accepted.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  DATA_WIDTH  returned read data.
- rd_err  out  1  sticky flag: read timeout occurred.
- cmd_ready  in  1  controller able to accept a command.
- cmd_enable  out  1  command present.
- cmd_wr  out  1  1 = write, 0 = read.
- cmd_address  out  ADDR_WIDTH  command address.
- cmd_data_in  out  DATA_WIDTH  command write data.
- data_out  in  DATA_WIDTH  controller read data.
- data_out_ready  in  1  controller read data valid.
- busy  out  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement states IDLE, ISSUE_WR, ISSUE_RD, RD_WAIT.
REQ-007 Requesters SHALL hold req, addr and data stable until their ack; arbiter SHALL sample addr and data only on the IDLE->ISSUE transition.
REQ-008 IDLE transitions:
- wr_req only -> ISSUE_WR.
- rd_req only -> ISSUE_RD.
- both -> ISSUE_WR, unless starve_cnt == STARVE_LIMIT, then ISSUE_RD.
- neither -> stay in IDLE.
REQ-009 In ISSUE_x the arbiter SHALL drive cmd_enable=1 with registered cmd_wr, cmd_address and cmd_data_in; these SHALL stay constant until acceptance.
REQ-010 Acceptance SHALL be the cycle in which cmd_enable && cmd_ready; on the next cycle cmd_enable SHALL be 0.
REQ-011 On write acceptance: wr_ack pulses on the next cycle; state returns to IDLE.
REQ-012 On read acceptance: rd_ack pulses on the next cycle; state goes to RD_WAIT.
REQ-013 Minimum write throughput SHALL be one command per 3 cycles (IDLE, ISSUE, IDLE).
REQ-014 In RD_WAIT:
- data_out_ready=1 -> register data_out into rd_data, pulse rd_valid on the next cycle, go to IDLE.
- no new command SHALL be issued while in RD_WAIT (single outstanding read).
REQ-015 An 8-bit wait counter SHALL clear on entry to RD_WAIT. If it reaches RD_TIMEOUT without data_out_ready: set rd_err, pulse rd_valid with rd_data = 0, go to IDLE.
REQ-016 data_out_ready outside RD_WAIT SHALL be ignored.
REQ-017 starve_cnt rules:
- increments, saturating at STARVE_LIMIT, on each write grant made while rd_req=1.
- clears on any read grant.
- clears on any IDLE cycle with rd_req=0.
REQ-018 rd_err SHALL clear only on reset.
REQ-019 cmd_ready deasserted indefinitely SHALL hold ISSUE_x with outputs stable; there is no timeout on issue.

Reset
REQ-020 While reset_n=0, asynchronously:
- state=IDLE.
- cmd_enable, cmd_wr, wr_ack, rd_ack, rd_valid, rd_err, busy = 0.
- cmd_address, cmd_data_in, rd_data = 0.
- starve_cnt and wait counter = 0.
REQ-021 Reset mid-command SHALL abandon the command with no ack; a read outstanding at reset SHALL never produce rd_valid.

Configuration
REQ-022 Macro SDRAM_ARB_FAIRNESS_EN:
- defined: starvation guard per REQ-008 and REQ-017.
- undefined: writes have strict priority; starve_cnt SHALL be absent, and reads are granted only when wr_req=0.

Verification
REQ-023 Single write: wr_req with addr 0x000010, data 0xA5A5A5A5, cmd_ready=1 -> one cmd_enable cycle with cmd_wr=1 and those values, then wr_ack pulse.
REQ-024 Read: rd_req with addr 0x000020; data_out=0x00123456 with data_out_ready 5 cycles after acceptance -> rd_ack, then rd_valid with rd_data=0x00123456.
REQ-025 Contention (fairness enabled): wr_req held continuously, rd_req asserted -> exactly 8 write grants, then a read grant; with the macro undefined, no read grant occurs.
REQ-026 Backpressure: cmd_ready=0 for 20 cycles during ISSUE_WR -> cmd_enable and cmd_address stable throughout, wr_ack only after cmd_ready rises.
REQ-027 Timeout: read accepted, data_out_ready never asserted -> after 255 cycles rd_valid with rd_data=0 and rd_err=1; a subsequent write completes normally.
REQ-028 Reset: reset_n low while in RD_WAIT, then data_out_ready after release -> no rd_valid, all outputs at reset values.
